// File: rtl/scanchain_pkg.sv
// Shared scan-chain definitions: default frame geometry and receiver FSM encodings.
package scanchain_pkg;
  localparam int ADDR_BITS_DEF    = 12;
  localparam int PAYLOAD_BITS_DEF = 160;
  localparam int FRAME_BITS       = ADDR_BITS_DEF + PAYLOAD_BITS_DEF;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
endpackage

// File: rtl/scanchain_receiver_sync.sv
// Multi-flop synchronizer for one scan pin with rise/fall pulses off the synced level.
module scan_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Deliberately unreset: a reset here would fabricate edges on pins that are already high.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    prev_q <= sync_q[SYNC_STAGES-1];
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;
endmodule

// File: rtl/scanchain_receiver.sv
// Oversampling scan-chain sink: shifts one addr+payload frame per scan_en window, valid/ready out.
module scanchain_receiver
  import scanchain_pkg::*;
#(
  parameter int ADDR_BITS    = ADDR_BITS_DEF,
  parameter int PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    scan_clk,
  input  logic                    scan_en,
  input  logic                    scan_in,
  input  logic                    scan_reset,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_BITS-1:0]    out_addr,
  output logic [PAYLOAD_BITS-1:0] out_payload,
  output logic                    frame_error,
  output logic                    overrun,
  output logic [1:0]              debug_state
);
  localparam int FRAME_W = ADDR_BITS + PAYLOAD_BITS;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  // Pin order: 0 scan_clk, 1 scan_en, 2 scan_in, 3 scan_reset
  logic [3:0] pin, lvl, rise, fall;
  assign pin = {scan_reset, scan_in, scan_en, scan_clk};

  for (genvar i = 0; i < 4; i++) begin : g_sync
    scan_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .async_in (pin[i]),
      .level    (lvl[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{lvl[0], fall[0], rise[2], fall[2], rise[3], fall[3]};

  logic [1:0]         state;
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
      out_payload <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (lvl[3]) begin
        state   <= IDLE;
        shreg   <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (rise[1]) begin
            bit_cnt <= '0;
            state   <= SHIFT;
          end
          SHIFT: begin
            // Closing edge wins over a coincident scan_clk rise.
            if (fall[1]) state <= CHECK;
            else if (rise[0] && lvl[1]) begin
              shreg <= {shreg[FRAME_W-2:0], lvl[2]};
              if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
            end
          end
          CHECK: begin
            state <= IDLE;
            if (bit_cnt == CNT_FULL) begin
              if (!out_valid || out_ready) begin
                out_valid   <= 1'b1;
                out_addr    <= shreg[FRAME_W-1:PAYLOAD_BITS];
                out_payload <= shreg[PAYLOAD_BITS-1:0];
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_error <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign debug_state = state;
endmodule

// File: tb/tb_scanchain_receiver.sv
// Directed bench for scanchain_receiver: good/short/long frames, overrun, scan reset, reset, coincident edges.
module tb_scanchain_receiver;
  import scanchain_pkg::*;

  logic         clk = 1'b0;
  logic         reset, scan_clk, scan_en, scan_in, scan_reset, out_ready;
  logic         out_valid, frame_error, overrun;
  logic [11:0]  out_addr;
  logic [159:0] out_payload;
  logic [1:0]   debug_state;

  int checks = 0, errors = 0;
  int err_cycles = 0, acc_cnt = 0;
  logic [11:0] last_addr = '0;

  scanchain_receiver dut (
    .clk(clk), .reset(reset), .scan_clk(scan_clk), .scan_en(scan_en),
    .scan_in(scan_in), .scan_reset(scan_reset), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .out_payload(out_payload),
    .frame_error(frame_error), .overrun(overrun), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_error) err_cycles++;
    if (out_valid && out_ready) begin
      acc_cnt++;
      last_addr = out_addr;
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [255:0] frm(input logic [11:0] a, input logic [159:0] p);
    return {84'b0, a, p};
  endfunction

  task automatic send_bits(input logic [255:0] bits, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      scan_in = bits[i];
      repeat (half) tick();
      scan_clk = 1'b1;
      repeat (half) tick();
      scan_clk = 1'b0;
    end
  endtask

  task automatic open_frame();
    scan_en = 1'b1;
    repeat (4) tick();
  endtask

  // Returns at the sample point where out_valid/frame_error for this frame should show.
  task automatic close_frame();
    scan_en = 1'b0;
    repeat (3) tick();
    chk("state_check", 256'(debug_state), 256'(CHECK));
    tick();
  endtask

  initial begin
    int e0, a0;
    int lens [3];
    int cnts [3];
    logic [255:0] f;
    lens = '{171, 173, 175};
    cnts = '{171, 173, 173};

    reset = 1'b1; scan_clk = 0; scan_en = 0; scan_in = 0; scan_reset = 0; out_ready = 1'b1;
    repeat (4) tick();
    chk("rst_valid",   256'(out_valid),   256'(0));
    chk("rst_addr",    256'(out_addr),    256'(0));
    chk("rst_payload", 256'(out_payload), 256'(0));
    chk("rst_ferr",    256'(frame_error), 256'(0));
    chk("rst_overrun", 256'(overrun),     256'(0));
    chk("rst_state",   256'(debug_state), 256'(IDLE));
    reset = 1'b0;
    repeat (2) tick();

    // Good frame, slow scan clock
    e0 = err_cycles; a0 = acc_cnt;
    open_frame();
    send_bits(frm(12'hABC, 160'h1), 172, 20);
    close_frame();
    chk("good_valid",   256'(out_valid),   256'(1));
    chk("good_addr",    256'(out_addr),    256'(12'hABC));
    chk("good_payload", 256'(out_payload), 256'(160'h1));
    tick();
    chk("good_drop",    256'(out_valid),   256'(0));
    chk("good_acc",     256'(acc_cnt),     256'(a0 + 1));
    chk("good_noerr",   256'(err_cycles),  256'(e0));
    repeat (4) tick();

    // Short and long frames
    for (int k = 0; k < 3; k++) begin
      e0 = err_cycles;
      open_frame();
      send_bits(frm(12'hABC, 160'h1234), lens[k], 6);
      close_frame();
      chk("bad_ferr",   256'(frame_error), 256'(1));
      chk("bad_valid",  256'(out_valid),   256'(0));
      tick();
      chk("bad_pulse",  256'(err_cycles),  256'(e0 + 1));
      chk("bad_cnt",    256'(dut.bit_cnt), 256'(cnts[k]));
      repeat (4) tick();
    end

    // Overrun
    out_ready = 1'b0; a0 = acc_cnt;
    open_frame();
    send_bits(frm(12'h001, 160'hDEAD), 172, 6);
    close_frame();
    chk("ovr_valid1", 256'(out_valid), 256'(1));
    chk("ovr_addr1",  256'(out_addr),  256'(12'h001));
    repeat (4) tick();
    open_frame();
    send_bits(frm(12'h002, 160'hBEEF), 172, 6);
    close_frame();
    chk("ovr_flag",    256'(overrun),     256'(1));
    chk("ovr_valid2",  256'(out_valid),   256'(1));
    chk("ovr_addr2",   256'(out_addr),    256'(12'h001));
    chk("ovr_payload", 256'(out_payload), 256'(160'hDEAD));
    chk("ovr_noferr",  256'(frame_error), 256'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ovr_drop",  256'(out_valid), 256'(0));
    repeat (50) tick();
    chk("ovr_never", 256'(out_valid), 256'(0));
    chk("ovr_stick", 256'(overrun),   256'(1));
    chk("ovr_acc",   256'(acc_cnt),   256'(a0 + 1));
    chk("ovr_last",  256'(last_addr), 256'(12'h001));

    // Scan reset mid-frame
    out_ready = 1'b1; e0 = err_cycles; a0 = acc_cnt;
    open_frame();
    send_bits(frm(12'h777, 160'hFFFF_FFFF), 80, 6);
    scan_reset = 1'b1;
    repeat (6) tick();
    chk("srst_state", 256'(debug_state), 256'(IDLE));
    chk("srst_cnt",   256'(dut.bit_cnt), 256'(0));
    scan_en = 1'b0;
    repeat (6) tick();
    scan_reset = 1'b0;
    repeat (6) tick();
    open_frame();
    send_bits(frm(12'h5A5, 160'h5A5A), 172, 6);
    close_frame();
    chk("srst_valid",   256'(out_valid),   256'(1));
    chk("srst_addr",    256'(out_addr),    256'(12'h5A5));
    chk("srst_payload", 256'(out_payload), 256'(160'h5A5A));
    tick();
    chk("srst_acc",   256'(acc_cnt),    256'(a0 + 1));
    chk("srst_noerr", 256'(err_cycles), 256'(e0));
    repeat (4) tick();

    // Reset with held output and a frame in flight
    out_ready = 1'b0;
    open_frame();
    send_bits(frm(12'h111, 160'h11), 172, 6);
    close_frame();
    chk("hrst_valid", 256'(out_valid), 256'(1));
    repeat (4) tick();
    open_frame();
    send_bits(frm(12'h222, 160'h22), 172, 6);
    close_frame();
    chk("hrst_ovr", 256'(overrun), 256'(1));
    repeat (4) tick();
    e0 = err_cycles;
    f = frm(12'h333, 160'h33);
    open_frame();
    send_bits(f, 50, 6);
    chk("hrst_shift", 256'(debug_state), 256'(SHIFT));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("hrst_o_valid",   256'(out_valid),   256'(0));
    chk("hrst_o_addr",    256'(out_addr),    256'(0));
    chk("hrst_o_payload", 256'(out_payload), 256'(0));
    chk("hrst_o_ovr",     256'(overrun),     256'(0));
    chk("hrst_o_ferr",    256'(frame_error), 256'(0));
    chk("hrst_o_state",   256'(debug_state), 256'(IDLE));
    send_bits(f, 122, 6);
    scan_en = 1'b0;
    repeat (10) tick();
    chk("hrst_gone",  256'(out_valid),   256'(0));
    chk("hrst_idle",  256'(debug_state), 256'(IDLE));
    chk("hrst_noerr", 256'(err_cycles),  256'(e0));

    // scan_clk rise coincident with scan_en fall after a full frame
    out_ready = 1'b1;
    f = frm(12'h3C3, 160'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEF);
    open_frame();
    send_bits(f, 172, 6);
    scan_in = 1'b1;
    repeat (6) tick();
    scan_clk = 1'b1;
    scan_en  = 1'b0;
    repeat (3) tick();
    chk("coin_state", 256'(debug_state), 256'(CHECK));
    tick();
    chk("coin_valid",   256'(out_valid),   256'(1));
    chk("coin_addr",    256'(out_addr),    256'(12'h3C3));
    chk("coin_payload", 256'(out_payload), 256'(160'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEF));
    chk("coin_ferr",    256'(frame_error), 256'(0));
    chk("coin_cnt",     256'(dut.bit_cnt), 256'(172));
    scan_clk = 1'b0;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
